// File: rtl/stream_pair_check.sv
// rtl/stream_pair_check.sv - joins a stream with its delayed bitwise inverse, recovers A, counts errors.
// Optional registered output path: define STREAM_PAIR_CHECK_OUT_REG_EN.
module stream_pair_check #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     a_tdata,
    input  logic                 a_tlast,
    input  logic                 a_tvalid,
    output logic                 a_tready,
    input  logic [WIDTH-1:0]     b_tdata,
    input  logic                 b_tlast,
    input  logic                 b_tvalid,
    output logic                 b_tready,
    output logic [WIDTH-1:0]     o_tdata,
    output logic                 o_tlast,
    output logic                 o_tvalid,
    input  logic                 o_tready,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [CNT_WIDTH-1:0] pkt_count,
    output logic                 mismatch,
    output logic                 resync
);

    typedef enum logic [1:0] {
        S_JOIN    = 2'd0,
        S_DRAIN_A = 2'd1,
        S_DRAIN_B = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t               state;
    logic                 flush;
    logic                 out_ready;
    logic                 join_ok;
    logic                 data_mm;
    logic                 last_mm;
    logic                 out_last;
    logic [1:0]           err_inc;
    logic [CNT_WIDTH:0]   err_sum;
    logic [CNT_WIDTH-1:0] err_next;

    assign flush    = reset | clear;
    assign data_mm  = (b_tdata != ~a_tdata);
    assign last_mm  = a_tlast ^ b_tlast;
    assign out_last = a_tlast | b_tlast;

    // Both streams are taken together or not at all, so they can never slip apart while joining.
    assign join_ok  = (state == S_JOIN) & a_tvalid & b_tvalid & out_ready & ~flush;
    assign a_tready = join_ok | (~flush & (state == S_DRAIN_A));
    assign b_tready = join_ok | (~flush & (state == S_DRAIN_B));

    always_comb begin
        err_inc  = {1'b0, join_ok & data_mm} + {1'b0, join_ok & last_mm};
        err_sum  = {1'b0, err_count} + {{(CNT_WIDTH-1){1'b0}}, err_inc};
        err_next = err_sum[CNT_WIDTH] ? CNT_MAX : err_sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            state     <= S_JOIN;
            err_count <= '0;
            pkt_count <= '0;
            mismatch  <= 1'b0;
            resync    <= 1'b0;
        end else begin
            mismatch  <= join_ok & data_mm;
            resync    <= join_ok & last_mm;
            err_count <= err_next;
            // Counted at the join so both output builds share identical counter timing.
            if (join_ok && out_last && (pkt_count != CNT_MAX))
                pkt_count <= pkt_count + CNT_WIDTH'(1);
            case (state)
                S_JOIN: begin
                    if (join_ok && a_tlast && !b_tlast)
                        state <= S_DRAIN_B;
                    else if (join_ok && b_tlast && !a_tlast)
                        state <= S_DRAIN_A;
                end
                S_DRAIN_A: begin
                    if (a_tvalid && a_tlast)
                        state <= S_JOIN;
                end
                S_DRAIN_B: begin
                    if (b_tvalid && b_tlast)
                        state <= S_JOIN;
                end
                default: state <= S_JOIN;
            endcase
        end
    end

`ifdef STREAM_PAIR_CHECK_OUT_REG_EN
    logic [WIDTH:0] mem [2];
    logic           wr_ptr;
    logic           rd_ptr;
    logic [1:0]     count;
    logic           pop;

    assign out_ready = (count != 2'd2);
    assign pop       = (count != 2'd0) & o_tready;
    assign o_tvalid  = (count != 2'd0);
    assign o_tdata   = mem[rd_ptr][WIDTH-1:0];
    assign o_tlast   = mem[rd_ptr][WIDTH];

    always_ff @(posedge clk) begin
        if (join_ok)
            mem[wr_ptr] <= {out_last, a_tdata};
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (join_ok)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, join_ok} - {1'b0, pop};
        end
    end
`else
    assign out_ready = o_tready;
    assign o_tvalid  = (state == S_JOIN) & a_tvalid & b_tvalid & ~flush;
    assign o_tdata   = a_tdata;
    assign o_tlast   = out_last;
`endif

endmodule

// File: doc/stream_pair_check.md
STREAM_PAIR_CHECK -- requirements
Module: stream_pair_check

Interface
REQ-001 SHALL have parameter WIDTH, default 32: tdata width of both input streams and the output stream.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the error and packet counters.
REQ-003 SHALL have ports clk (input, 1): the single clock; reset (input, 1): synchronous, active-high.
REQ-004 SHALL have port clear (input, 1): synchronous soft clear.
REQ-005 SHALL have ports a_tdata (input, WIDTH), a_tlast, a_tvalid (input, 1) and a_tready (output, 1): pass-through stream.
REQ-006 SHALL have ports b_tdata (input, WIDTH), b_tlast, b_tvalid (input, 1) and b_tready (output, 1): inverted stream, arriving at an arbitrary latency relative to A.
REQ-007 SHALL have ports o_tdata (output, WIDTH), o_tlast, o_tvalid (output, 1) and o_tready (input, 1): the recovered A stream.
REQ-008 SHALL have outputs err_count (CNT_WIDTH), pkt_count (CNT_WIDTH), mismatch (1) and resync (1).

Function
REQ-009 SHALL implement the state machine S_JOIN, S_DRAIN_A and S_DRAIN_B, entering S_JOIN from reset.
REQ-010 In S_JOIN, a beat SHALL be consumed only when a_tvalid, b_tvalid and output-side ready are all 1; a_tready and b_tready SHALL assert on exactly the same cycles.
REQ-011 In S_JOIN, ready SHALL NOT depend on the state of the other stream's valid in a way that consumes one stream alone; no single-stream consumption occurs.
REQ-012 A joined beat SHALL be a data mismatch when b_tdata != ~a_tdata (bitwise, all WIDTH bits).
REQ-013 On a joined beat, o_tdata SHALL be a_tdata and o_tlast SHALL be a_tlast | b_tlast.
REQ-014 On a joined beat with a_tlast=1 and b_tlast=0, the FSM SHALL enter S_DRAIN_B.
REQ-015 On a joined beat with b_tlast=1 and a_tlast=0, the FSM SHALL enter S_DRAIN_A.
REQ-016 In S_DRAIN_B, the block SHALL hold a_tready=0, hold b_tready=1 and discard B beats without producing output.
REQ-017 On the B beat with b_tlast=1 (inclusive), the FSM SHALL return from S_DRAIN_B to S_JOIN; S_DRAIN_A SHALL behave symmetrically.
REQ-018 mismatch SHALL be a one-cycle pulse in the cycle after a joined beat that has a data mismatch.
REQ-019 resync SHALL be a one-cycle pulse in the cycle after entry to either drain state.
REQ-020 err_count SHALL increment by 1 per data-mismatch beat and by 1 per entry to a drain state.
REQ-021 When a data-mismatch beat is also a tlast mismatch, err_count SHALL increment by 2 in total.
REQ-022 err_count SHALL saturate at all-ones with no wrap.
REQ-023 pkt_count SHALL increment by 1 per output beat accepted with o_tlast=1, SHALL saturate at all-ones, and SHALL NOT count drained beats.
REQ-024 Counters SHALL be registered and update in the cycle after the causing event.
REQ-025 The input streams SHALL NOT be stalled by counter saturation.

Reset
REQ-026 On reset=1 at a clk edge: state=S_JOIN; err_count=0; pkt_count=0; mismatch=0; resync=0; o_tvalid=0; any output register emptied.
REQ-027 While reset=1, a_tready=0 and b_tready=0.
REQ-028 clear SHALL have the same effect as reset.
REQ-029 clear and reset asserted mid-packet or mid-drain SHALL abandon the packet; no output beat is produced for the interrupted beats.
REQ-030 reset SHALL take priority over clear, and both SHALL take priority over any beat in the same cycle.

Configuration
REQ-031 Macro STREAM_PAIR_CHECK_OUT_REG_EN SHALL select the output path.
REQ-032 With STREAM_PAIR_CHECK_OUT_REG_EN defined: output SHALL be taken from a 2-entry registered skid buffer; latency is 1 cycle from joined beat to o_tvalid.
REQ-033 With STREAM_PAIR_CHECK_OUT_REG_EN defined: output-side ready is the buffer not being full, and full throughput (1 beat/cycle) SHALL be sustained with o_tready=1.
REQ-034 Without the macro: o_tvalid SHALL equal a_tvalid & b_tvalid while in S_JOIN, output-side ready SHALL equal o_tready, and latency SHALL be 0 (combinational).
REQ-035 Counter and pulse timing relative to the joined beat SHALL be identical in both builds.

Verification
REQ-036 A = 0x00000001..0x00000004 (tlast on 4th), B = bitwise inverse delayed 3 cycles, o_tready=1 -> o_tdata 1..4, o_tlast on 4th only, pkt_count=1, err_count=0, mismatch never set.
REQ-037 B beat 2 = 0x00000000 instead of 0xFFFFFFFD -> mismatch pulses once, err_count=1, o_tdata still 0x00000002.
REQ-038 A tlast on beat 2 while B packet is 4 beats -> output packet of 2 beats ending with tlast, resync pulse, B beats 3-4 dropped, err_count=1; next packet aligns with err_count unchanged.
REQ-039 o_tready toggled 1/0 every cycle over a 16-beat packet -> no beat lost or duplicated, a_tready==b_tready on every cycle; with OUT_REG_EN, throughput is 1 beat/cycle when o_tready=1.
REQ-040 clear pulsed in S_DRAIN_B with err_count=5 -> next cycle state S_JOIN, err_count=0, pkt_count=0, o_tvalid=0; the next aligned packet passes cleanly.
REQ-041 With CNT_WIDTH=2, 5 mismatching beats -> err_count holds 3 with no wrap.
